// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared types and defaults for the SPI master controller slice.
//   spi_state_e          : controller FSM states
//   SPI_DATA_W_DEFAULT   : default bits per SPI word
//   SPI_TIMEOUT_DEFAULT  : default WAIT_RX inter-beat timeout (cycles)
// -----------------------------------------------------------------------------
package spi_pkg;

  localparam int SPI_DATA_W_DEFAULT  = 8;
  localparam int SPI_TIMEOUT_DEFAULT = 64;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SELECT  = 3'd1,
    SHIFT   = 3'd2,
    WAIT_RX = 3'd3,
    DONE    = 3'd4
  } spi_state_e;

endpackage

// File: rtl/spi_master_ctrl_if.sv
// -----------------------------------------------------------------------------
// spi_master_ctrl_if
// Bundles the host-side word handshake and the SPI-side serial signals.
//   tx_data/tx_valid/tx_ready : word in from host
//   rx_data/rx_valid/rx_err   : word (or timeout) back to host
//   ss_n/MOSI                 : select and serial data to slave
//   MISO/valid_MISO/sready    : serial data, bit strobe and ready from slave
// Modports: master (the controller), slave (host + slave side, e.g. a bench).
// -----------------------------------------------------------------------------
interface spi_master_ctrl_if
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W_DEFAULT
) ();

  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_err;
  logic              ss_n;
  logic              MOSI;
  logic              MISO;
  logic              valid_MISO;
  logic              sready;

  modport master (
    input  tx_data, tx_valid,
    output tx_ready,
    output rx_data, rx_valid, rx_err,
    output ss_n, MOSI,
    input  MISO, valid_MISO, sready
  );

  modport slave (
    output tx_data, tx_valid,
    input  tx_ready,
    input  rx_data, rx_valid, rx_err,
    input  ss_n, MOSI,
    output MISO, valid_MISO, sready
  );

endinterface

// File: rtl/spi_shift_reg.sv
// -----------------------------------------------------------------------------
// spi_shift_reg
// Generic MSB-first shift register used for both the TX and RX paths.
//   clk, rst   : clock, asynchronous active-high reset (clears contents)
//   load       : parallel load of load_data (has priority over shift_en)
//   shift_en   : shift left by one, ser_in entering at bit 0
//   ser_out    : current MSB (serial out, MSB first)
//   par_out    : full register contents
// DATA_W must be at least 2.
// -----------------------------------------------------------------------------
module spi_shift_reg
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              shift_en,
  input  logic              ser_in,
  output logic              ser_out,
  output logic [DATA_W-1:0] par_out
);

  logic [DATA_W-1:0] sr_q;
  logic [DATA_W-1:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = load_data;
    end else if (shift_en) begin
      sr_d = {sr_q[DATA_W-2:0], ser_in};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign ser_out = sr_q[DATA_W-1];
  assign par_out = sr_q;

endmodule

// File: rtl/spi_master_ctrl.sv
// -----------------------------------------------------------------------------
// spi_master_ctrl
// SPI master: accepts one word from the host, selects the slave for one
// cycle, shifts the word out MSB first, then collects DATA_W MISO bits
// (strobed by valid_MISO) and returns them with a one-cycle rx_valid pulse.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : spi_master_ctrl_if.master (host handshake + SPI pins)
// Optional feature macro: SPI_MASTER_TIMEOUT_EN
//   defined   -> WAIT_RX aborts with a one-cycle rx_err pulse after TIMEOUT
//                cycles without a valid_MISO beat
//   undefined -> WAIT_RX waits indefinitely, rx_err is tied low
// -----------------------------------------------------------------------------
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int DATA_W  = SPI_DATA_W_DEFAULT,
  parameter int TIMEOUT = SPI_TIMEOUT_DEFAULT
) (
  input logic               clk,
  input logic               rst,
  spi_master_ctrl_if.master bus
);

  localparam int               CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  spi_state_e        state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;

  logic              accept;
  logic              tx_load, tx_shift;
  logic              rx_clear, rx_shift;
  logic              tx_ser;
  logic [DATA_W-1:0] rx_par;
  logic              timeout_hit;
  logic [DATA_W-1:0] unused_tx_par;
  logic              unused_rx_ser;

  // tx_ready is gated by rst so it reads 0 while reset is held.
  assign bus.tx_ready = (state_q == IDLE) && bus.sready && !rst;
  assign accept       = bus.tx_valid && bus.tx_ready;

  spi_shift_reg #(.DATA_W(DATA_W)) u_tx_sr (
    .clk      (clk),
    .rst      (rst),
    .load     (tx_load),
    .load_data(bus.tx_data),
    .shift_en (tx_shift),
    .ser_in   (1'b0),
    .ser_out  (tx_ser),
    .par_out  (unused_tx_par)
  );

  spi_shift_reg #(.DATA_W(DATA_W)) u_rx_sr (
    .clk      (clk),
    .rst      (rst),
    .load     (rx_clear),
    .load_data('0),
    .shift_en (rx_shift),
    .ser_in   (bus.MISO),
    .ser_out  (unused_rx_ser),
    .par_out  (rx_par)
  );

`ifdef SPI_MASTER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  // Counts consecutive beat-less WAIT_RX cycles; zero outside WAIT_RX so it
  // starts fresh on entry. The abort fires in the TIMEOUT-th such cycle.
  assign timeout_hit = (state_q == WAIT_RX) && !bus.valid_MISO &&
                       (to_cnt_q == TO_W'(TIMEOUT - 1));

  always_comb begin
    to_cnt_d = '0;
    if ((state_q == WAIT_RX) && !bus.valid_MISO && !timeout_hit) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  localparam int unused_timeout = TIMEOUT;

  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_data_d = rx_data_q;
    tx_load   = 1'b0;
    tx_shift  = 1'b0;
    rx_clear  = 1'b0;
    rx_shift  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          tx_load = 1'b1;
          state_d = SELECT;
        end
      end
      SELECT: begin
        bit_cnt_d = '0;
        state_d   = SHIFT;
      end
      SHIFT: begin
        tx_shift = 1'b1;
        if (bit_cnt_q == LAST_BIT) begin
          bit_cnt_d = '0;
          rx_clear  = 1'b1;
          state_d   = WAIT_RX;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      WAIT_RX: begin
        if (timeout_hit) begin
          state_d = IDLE;
        end else if (bus.valid_MISO) begin
          rx_shift  = 1'b1;
          // Ends at DATA_W on the final beat, never past it.
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == LAST_BIT) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        rx_data_d = rx_par;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      rx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rx_data_q <= rx_data_d;
    end
  end

  assign bus.ss_n     = !((state_q == SELECT) || (state_q == SHIFT) ||
                          ((state_q == WAIT_RX) && !timeout_hit));
  assign bus.MOSI     = (state_q == SHIFT) && tx_ser;
  assign bus.rx_valid = (state_q == DONE);
  // In DONE the RX shift register already holds the full word; afterwards the
  // captured copy keeps it stable while the next transaction shifts in.
  assign bus.rx_data  = (state_q == DONE) ? rx_par : rx_data_q;
  assign bus.rx_err   = timeout_hit;

endmodule
